rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, write address, write data) among NUM_REQ writeback sources: ALU, load unit, mul/CSR.
- Round-robin arbitration with valid/ready handshake, one registered output stage, and a pending-write scoreboard that decode uses for hazard checks.
- Sits between the execute/memory writeback paths and Register_File.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-source write request
- req_ready  out  NUM_REQ  per-source grant, combinational
- req_addr  in  NUM_REQ*RA_W  per-source destination register, source i at [i*RA_W +: RA_W]
- req_data  in  NUM_REQ*XLEN  per-source write data, source i at [i*XLEN +: XLEN]
- wb_hold  in  1  freeze write port (debug halt / pipeline flush window)
- issue_valid  in  1  decode issued an instruction that writes issue_rd
- issue_rd  in  RA_W  destination of the issued instruction
- rf_we  out  1  to Register_File write enable
- rf_addr  out  RA_W  to Register_File write address
- rf_wdata  out  XLEN  to Register_File write data
- pend_mask  out  32  bit r set means a write to xr is outstanding

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, stage_valid=0, stage_addr=0, stage_data=0, pend_mask=0.
  - Therefore rf_we=0, rf_addr=0, rf_wdata=0.
  - An in-flight staged write is discarded and never reaches the register file.
- Arbitration:
  - Combinational.
  - Source priority order is rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - Exactly one req_ready is asserted: the first valid source in that order, and only when stage_free is true.
  - stage_free = ~stage_valid | ~wb_hold.
  - No valid source: no ready, rr_ptr unchanged.
  - req_ready may depend on req_valid. Sources must hold valid/addr/data stable until accepted.
- Accept (valid & ready on source g):
  - Next edge: stage_valid=1, stage_addr=req_addr[g], stage_data=req_data[g].
  - rr_ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Destination x0:
  - A request with addr 0 is accepted and rotates rr_ptr.
  - stage_valid is loaded 0, so no write is produced.
- Output stage:
  - rf_we = stage_valid & ~wb_hold.
  - rf_addr = stage_addr and rf_wdata = stage_data whenever stage_valid; both are 0 otherwise.
  - Latency is exactly 1 cycle from accept to rf_we.
  - The register file commits on the following rising edge.
- wb_hold:
  - A held, valid stage keeps its contents, rf_we=0, and all req_ready=0.
  - An empty stage still accepts while held; the stage is then held next cycle.
  - When hold drops, the staged write is presented that cycle.
- Stage drain: a non-held stage drains each cycle and may be reloaded the same cycle, giving back-to-back writes at 1/cycle.
- Scoreboard:
  - Set: issue_valid & issue_rd!=0 sets pend_mask[issue_rd].
  - Clear: rf_we clears pend_mask[rf_addr].
  - Set and clear of the same bit in one cycle: set wins (newer producer).
  - pend_mask[0] is always 0.
- Starvation bound: a continuously valid source is granted within NUM_REQ accepted grants.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined adds ports:
  - rd_a1, rd_a2  in  RA_W
  - rf_rd1, rf_rd2  in  XLEN
  - fwd_rd1, fwd_rd2  out  XLEN
- fwd_rdN = (rf_we & rf_addr==rd_aN & rd_aN!=0) ? rf_wdata : rf_rdN, purely combinational. This lets decode see the write committing at the coming edge.
- Undefined: these ports are absent, and consumers read Register_File directly.

Decomposition:
- Package rf_ctrl_pkg:
  - XLEN, RA_W, NUM_REGS=32
  - typedef wb_req_t {logic [RA_W-1:0] addr; logic [XLEN-1:0] data;}
  - typedef pend_mask_t as a 32-bit vector
- Sub-module rr_arbiter (NUM_REQ; req, en, ptr -> one-hot grant, grant index), reusable elsewhere.
- Scoreboard and output stage stay inline.

Test Plan:
- Reset, then src0 valid addr=5 data=0xDEADBEEF -> ready0 same cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF; pend bit 5 cleared if set.
- All 3 sources valid continuously with addrs 1/2/3 -> grants 0,1,2,0,1,2; rf_we high every cycle from cycle 1.
- src1 valid addr=0 data=0x1234 -> ready1=1, no rf_we, rr_ptr becomes 2.
- issue_valid rd=7 at cycle 0; src2 writes addr 7 to commit at cycle 3 -> pend_mask[7]=1 cycles 1..3, 0 from cycle 4; repeat with issue rd=7 in the clear cycle -> bit stays 1.
- wb_hold=1 with staged addr=9 data=0x55 -> rf_we=0, req_ready=0, stage unchanged 3 cycles; hold drops -> rf_we=1, addr 9, data 0x55.
- Assert rst low with stage valid (addr=4) -> rf_we=0 immediately, pend_mask=0, no write to x4 after release. With RF_WB_BYPASS_EN defined, rd_a1=4 while rf_we addr 4 data 0xA5 -> fwd_rd1=0xA5.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file control slice.
package rf_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef logic [NUM_REGS-1:0] pend_mask_t;

  // Next round-robin pointer after granting index idx out of n sources.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr,
// wrapping mod NUM_REQ, and grants the first requester when en is high.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Priority search from ptr; only the first valid source in rotated order wins.
  always_comb begin
    automatic int  k;
    automatic logic found;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = i + int'(ptr);
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = en;
        gnt_idx = k[PTR_W-1:0];
      end
    end
    gnt_any = found & en;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin among NUM_REQ writeback
// sources, one registered output stage, and a pending-write scoreboard.
// Optional macro RF_WB_BYPASS_EN adds two read-forwarding ports that expose
// the write committing at the coming edge.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rf_ctrl_pkg::XLEN,
  parameter int RA_W    = rf_ctrl_pkg::RA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*RA_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic                    wb_hold,
  input  logic                    issue_valid,
  input  logic [RA_W-1:0]         issue_rd,
  output logic                    rf_we,
  output logic [RA_W-1:0]         rf_addr,
  output logic [XLEN-1:0]         rf_wdata,
`ifdef RF_WB_BYPASS_EN
  input  logic [RA_W-1:0]         rd_a1,
  input  logic [RA_W-1:0]         rd_a2,
  input  logic [XLEN-1:0]         rf_rd1,
  input  logic [XLEN-1:0]         rf_rd2,
  output logic [XLEN-1:0]         fwd_rd1,
  output logic [XLEN-1:0]         fwd_rd2,
`endif
  output logic [31:0]             pend_mask
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             stage_valid_q, stage_valid_d;
  logic [RA_W-1:0]  stage_addr_q, stage_addr_d;
  logic [XLEN-1:0]  stage_data_q, stage_data_d;
  pend_mask_t       pend_q, pend_d;

  logic             stage_free;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             accept;
  logic [RA_W-1:0]  sel_addr;
  logic [XLEN-1:0]  sel_data;

  // A held stage that still holds a write blocks new grants.
  assign stage_free = ~stage_valid_q | ~wb_hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .en      (stage_free),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (accept)
  );

  assign req_ready = gnt;

  // One-hot mux of the granted source's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*RA_W +: RA_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Output stage is transparent to the register file unless held.
  assign rf_we    = stage_valid_q & ~wb_hold;
  assign rf_addr  = stage_valid_q ? stage_addr_q : '0;
  assign rf_wdata = stage_valid_q ? stage_data_q : '0;

  // Stage load/drain and pointer rotation; x0 writes are accepted but dropped.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      stage_valid_d = (sel_addr != '0);
      stage_addr_d  = sel_addr;
      stage_data_d  = sel_data;
      rr_ptr_d      = PTR_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
    end else if (rf_we) begin
      stage_valid_d = 1'b0;
    end
  end

  // Scoreboard: commit clears, issue sets; a same-cycle issue wins over the clear.
  always_comb begin
    pend_d = pend_q;
    if (rf_we) pend_d[rf_addr] = 1'b0;
    if (issue_valid && issue_rd != '0) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign pend_mask = pend_q;

  // State registers; reset discards any in-flight staged write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      pend_q        <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      pend_q        <= pend_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the committing write to decode's read operands.
  assign fwd_rd1 = (rf_we && rf_addr == rd_a1 && rd_a1 != '0) ? rf_wdata : rf_rd1;
  assign fwd_rd2 = (rf_we && rf_addr == rd_a2 && rd_a2 != '0) ? rf_wdata : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*XL-1:0] req_data;
  logic            wb_hold;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [XL-1:0]   rf_wdata;
  logic [31:0]     pend_mask;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]   rd_a1, rd_a2;
  logic [XL-1:0]   rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .RA_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wb_hold     (wb_hold),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
`ifdef RF_WB_BYPASS_EN
    .rd_a1       (rd_a1),
    .rd_a2       (rd_a2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .fwd_rd1     (fwd_rd1),
    .fwd_rd2     (fwd_rd2),
`endif
    .pend_mask   (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*XL +: XL]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [AW-1:0] a, input logic [XL-1:0] d);
    check({tag, ".we"},   64'(rf_we),    64'(we));
    check({tag, ".addr"}, 64'(rf_addr),  64'(a));
    check({tag, ".data"}, 64'(rf_wdata), 64'(d));
  endtask

  int          gseq [6] = '{1, 2, 0, 1, 2, 0};
  logic [N-1:0] one_hot;

  initial begin
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    wb_hold = 1'b0; issue_valid = 1'b0; issue_rd = '0;
`ifdef RF_WB_BYPASS_EN
    rd_a1 = '0; rd_a2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    // Reset state
    tick(); tick();
    chk_out("reset", 1'b0, 5'd0, 32'd0);
    check("reset.pend", 64'(pend_mask), 64'd0);
    check("reset.ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();

    // Single write from src0
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("t1.ready", 64'(req_ready), 64'b001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'd0);
    chk_out("t1.out", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_out("t1.drain", 1'b0, 5'd0, 32'd0);

    // All sources valid: rr_ptr is 1, so grants go 1,2,0,1,2,0
    set_src(0, 1'b1, 5'd1, 32'h11);
    set_src(1, 1'b1, 5'd2, 32'h22);
    set_src(2, 1'b1, 5'd3, 32'h33);
    for (int c = 0; c < 6; c++) begin
      #1;
      one_hot = '0;
      one_hot[gseq[c]] = 1'b1;
      check($sformatf("t2.ready%0d", c), 64'(req_ready), 64'(one_hot));
      tick();
      chk_out($sformatf("t2.out%0d", c), 1'b1, 5'(gseq[c] + 1), 32'(32'h11 * (gseq[c] + 1)));
    end
    req_valid = '0;
    tick();
    check("t2.drain", 64'(rf_we), 64'd0);

    // x0 destination from src1 (ptr=1): accepted, no write, ptr -> 2
    set_src(1, 1'b1, 5'd0, 32'h1234);
    #1 check("t3.ready", 64'(req_ready), 64'b010);
    tick();
    set_src(1, 1'b0, 5'd0, 32'd0);
    chk_out("t3.out", 1'b0, 5'd0, 32'd0);
    set_src(0, 1'b1, 5'd10, 32'hA0);
    set_src(2, 1'b1, 5'd11, 32'hB0);
    #1 check("t3.ptr2", 64'(req_ready), 64'b100);
    tick();
    set_src(2, 1'b0, 5'd0, 32'd0);
    chk_out("t3.w11", 1'b1, 5'd11, 32'hB0);
    check("t3.ptr0", 64'(req_ready), 64'b001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'd0);
    chk_out("t3.w10", 1'b1, 5'd10, 32'hA0);
    tick();

    // Scoreboard: issue rd7, src2 commits at cycle 3 (ptr=1)
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("t4.pend_c1", 64'(pend_mask), 64'h80);
    tick();
    set_src(2, 1'b1, 5'd7, 32'h77);
    #1 check("t4.ready", 64'(req_ready), 64'b100);
    check("t4.pend_c2", 64'(pend_mask), 64'h80);
    tick();
    set_src(2, 1'b0, 5'd0, 32'd0);
    chk_out("t4.out", 1'b1, 5'd7, 32'h77);
    check("t4.pend_c3", 64'(pend_mask), 64'h80);
    tick();
    check("t4.pend_c4", 64'(pend_mask), 64'h0);
    // Same-cycle issue and clear: set wins (ptr=0)
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    set_src(0, 1'b1, 5'd7, 32'h70);
    tick();
    set_src(0, 1'b0, 5'd0, 32'd0);
    chk_out("t4.out2", 1'b1, 5'd7, 32'h70);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("t4.setwins", 64'(pend_mask), 64'h80);

    // Hold with staged addr 9 (ptr=1)
    set_src(1, 1'b1, 5'd9, 32'h55);
    tick();
    set_src(1, 1'b0, 5'd0, 32'd0);
    wb_hold = 1'b1;
    set_src(0, 1'b1, 5'd12, 32'hC);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_out($sformatf("t5.hold%0d", c), 1'b0, 5'd9, 32'h55);
      check($sformatf("t5.ready%0d", c), 64'(req_ready), 64'd0);
      tick();
    end
    wb_hold = 1'b0;
    #1 chk_out("t5.release", 1'b1, 5'd9, 32'h55);
    check("t5.reload", 64'(req_ready), 64'b001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'd0);
    chk_out("t5.b2b", 1'b1, 5'd12, 32'hC);
    tick();
    // Empty stage accepts while held (ptr=1)
    wb_hold = 1'b1;
    set_src(1, 1'b1, 5'd13, 32'hD);
    #1 check("t5.emptyacc", 64'(req_ready), 64'b010);
    tick();
    set_src(1, 1'b0, 5'd0, 32'd0);
    chk_out("t5.heldnew", 1'b0, 5'd13, 32'hD);
    wb_hold = 1'b0;
    #1 chk_out("t5.heldrel", 1'b1, 5'd13, 32'hD);
    tick();

    // Reset with stage valid addr 4 (ptr=2)
    set_src(2, 1'b1, 5'd4, 32'hA5);
    tick();
    set_src(2, 1'b0, 5'd0, 32'd0);
    chk_out("t6.staged", 1'b1, 5'd4, 32'hA5);
`ifdef RF_WB_BYPASS_EN
    rd_a1 = 5'd4; rf_rd1 = 32'h99; rd_a2 = 5'd5; rf_rd2 = 32'h66;
    #1 check("t6.fwd1", 64'(fwd_rd1), 64'hA5);
    check("t6.fwd2", 64'(fwd_rd2), 64'h66);
`endif
    rst = 1'b0;
    #1 chk_out("t6.rstnow", 1'b0, 5'd0, 32'd0);
    check("t6.pend", 64'(pend_mask), 64'd0);
    tick();
    rst = 1'b1;
    #1 chk_out("t6.after", 1'b0, 5'd0, 32'd0);
    req_valid = 3'b111;
    #1 check("t6.ptr0", 64'(req_ready), 64'b001);
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
